rr_arb_enc16: RTL and testbench

Round-robin arbiter sharing one resource among 16 requesters. It produces a registered one-hot grant and its 4-bit encoded index, so the 16-to-4 encoder path downstream always receives a single-hot vector. Each grant is held until the owner releases it or, optionally, until a hold timeout expires. A fixed turnaround gap separates consecutive owners.

---
 rtl/rr_arb_enc16.sv | 176 +++++++++++++++++
 tb/tb_rr_arb_enc16.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_enc16.sv
// ---------------------------------------------------------------------------
// rr_arb_enc16
//
// Round-robin arbiter that shares one resource among 16 requesters. The grant
// is a registered one-hot vector plus its registered 4-bit index, so anything
// downstream (for example a 16-to-4 encoder) only ever sees a single-hot input.
// An owner keeps the grant until it pulses done or drops its request line.
// With the optional timeout feature, the grant is also taken back after
// HOLD_MAX cycles. Every handover is followed by one GAP cycle in which no
// one holds the grant.
//
// Optional feature macro: RR_ARB_TIMEOUT_EN
//   defined   : hold counter, HOLD_MAX compare and timeout pulse are built
//   undefined : grants end only on done or request drop; timeout tied to 0
//
// Parameters
//   HOLD_MAX    : maximum cycles a grant may be held (1..255). Only used
//                 when timeout is enabled.
// Ports
//   clk         : clock; all state changes on its rising edge
//   reset       : synchronous, active-high reset
//   enable      : allows new grants; does not revoke a grant already held
//   req[15:0]   : level-sensitive request lines, bit i = requester i
//   done        : release strobe from the current owner, looked at in GRANT
//   grant[15:0] : registered one-hot grant, zero when there is no owner
//   grant_id    : binary index of the grant bit, zero when grant_valid is low
//   grant_valid : high while grant is non-zero
//   timeout     : one-cycle pulse, in the GAP cycle after a forced release
// ---------------------------------------------------------------------------
module rr_arb_enc16 #(
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] req,
   input  logic        done,
   output logic [15:0] grant,
   output logic [3:0]  grant_id,
   output logic        grant_valid,
   output logic        timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t     state;
   logic [3:0] ptr;

   logic       pick_found;
   logic [3:0] pick_id;
   logic [3:0] scan_idx;

   logic       vol_release;
   logic       force_release;

   // Catch an out-of-range HOLD_MAX when the design is elaborated, so a bad
   // value cannot silently wrap when it is truncated to the 8-bit counter.
   if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
      $error("rr_arb_enc16: HOLD_MAX must be in 1..255");
   end

   // Circular priority scan that starts at ptr. The loop runs from the
   // farthest offset down to offset 0. Later hits overwrite earlier ones, so
   // the requester closest to ptr (going upward with wrap) wins. The 4-bit
   // add gives the modulo-16 wrap for free.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = ptr;
      scan_idx   = '0;
      for (int k = 15; k >= 0; k--) begin
         scan_idx = ptr + 4'(k);
         if (req[scan_idx]) begin
            pick_found = 1'b1;
            pick_id    = scan_idx;
         end
      end
   end

   // A voluntary release is done from the owner or the owner dropping its
   // request line. It is only meaningful in GRANT, because grant_id is zero
   // in every other state.
   always_comb begin
      vol_release = done | ~req[grant_id];
   end

`ifdef RR_ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

   logic [7:0] hold_cnt;

   // Forced release happens only when the counter reaches HOLD_MAX and the
   // owner is not already letting go that same cycle. This way a voluntary
   // release always beats the timeout and never produces a timeout pulse.
   always_comb begin
      force_release = (state == GRANT) && (hold_cnt == HOLD_LIM) && !vol_release;
   end

   // The hold counter reads 1 during the first GRANT cycle and counts up each
   // further GRANT cycle, so it equals the number of cycles held so far. It
   // is loaded on the edge that enters GRANT and cleared on the edge that
   // leaves it. It saturates at 255, so it cannot wrap back below HOLD_MAX.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt <= '0;
      end else if (state == IDLE && enable && pick_found) begin
         hold_cnt <= 8'd1;
      end else if (state == GRANT && !(vol_release || force_release)) begin
         if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
         end
      end else begin
         hold_cnt <= '0;
      end
   end
`else
   // Without the timeout feature, only the owner can end a grant.
   always_comb begin
      force_release = 1'b0;
   end
`endif

   // Main IDLE -> GRANT -> GAP -> IDLE sequencer. All outputs are registered
   // here, so none of them has a combinational path from an input. grant and
   // grant_id are loaded together from the same scan result, which keeps
   // them consistent and keeps grant one-hot. On release the pointer moves to
   // the requester just after the old owner, so that owner gets the lowest
   // priority in the next round.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         grant       <= '0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
         ptr         <= '0;
      end else begin
         case (state)
            IDLE: begin
               timeout <= 1'b0;
               if (enable && pick_found) begin
                  grant       <= 16'(1) << pick_id;
                  grant_id    <= pick_id;
                  grant_valid <= 1'b1;
                  state       <= GRANT;
               end
            end
            GRANT: begin
               if (vol_release || force_release) begin
                  grant       <= '0;
                  grant_id    <= '0;
                  grant_valid <= 1'b0;
                  ptr         <= grant_id + 4'd1;
                  timeout     <= force_release;
                  state       <= GAP;
               end
            end
            GAP: begin
               timeout <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               grant       <= '0;
               grant_id    <= '0;
               grant_valid <= 1'b0;
               timeout     <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arb_enc16.sv
// ---------------------------------------------------------------------------
// tb_rr_arb_enc16
//
// Self-checking bench for rr_arb_enc16. The stimulus process drives one set
// of inputs per cycle. For each cycle it advances a behavioural model of the
// arbiter, which tracks the owner number, the GAP flag, the rotation pointer
// and the number of cycles held. The model pushes its expected outputs into
// a queue. A separate monitor pops one entry after every rising edge and
// compares it with the DUT outputs.
//
// When RR_ARB_TIMEOUT_EN is defined, the model also applies the HOLD_MAX
// limit, and the timeout scenarios are run as well.
// ---------------------------------------------------------------------------
module tb_rr_arb_enc16;

   localparam int HOLD = 4;

`ifdef RR_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] req = '0;
   logic        done = 1'b0;
   logic [15:0] grant;
   logic [3:0]  grant_id;
   logic        grant_valid;
   logic        timeout;

   typedef struct packed {
      logic [15:0] grant;
      logic [3:0]  id;
      logic        valid;
      logic        tout;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   // Model state: owner is -1 when nobody holds the grant.
   int m_owner = -1;
   bit m_gap   = 1'b0;
   int m_ptr   = 0;
   int m_hold  = 0;
   bit m_tout  = 1'b0;

   rr_arb_enc16 #(
      .HOLD_MAX(HOLD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .req        (req),
      .done       (done),
      .grant      (grant),
      .grant_id   (grant_id),
      .grant_valid(grant_valid),
      .timeout    (timeout)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   // Advance the model by one clock edge using the inputs that are currently
   // applied, then queue the outputs the DUT should show after that edge.
   task automatic modelStep(input bit rst, input bit en, input logic [15:0] r, input bit dn);
      exp_t e;
      bit   vol;
      bit   forced;
      if (rst) begin
         m_owner = -1;
         m_gap   = 1'b0;
         m_ptr   = 0;
         m_hold  = 0;
         m_tout  = 1'b0;
      end else if (m_owner >= 0) begin
         vol    = dn || !r[m_owner];
         forced = TO_EN && (m_hold == HOLD) && !vol;
         if (vol || forced) begin
            m_ptr   = (m_owner + 1) % 16;
            m_owner = -1;
            m_gap   = 1'b1;
            m_hold  = 0;
            m_tout  = forced;
         end else begin
            m_hold = (m_hold < 255) ? m_hold + 1 : 255;
            m_tout = 1'b0;
         end
      end else if (m_gap) begin
         m_gap  = 1'b0;
         m_tout = 1'b0;
      end else begin
         m_tout = 1'b0;
         if (en) begin
            for (int k = 0; k < 16; k++) begin
               if (m_owner < 0 && r[(m_ptr + k) % 16]) begin
                  m_owner = (m_ptr + k) % 16;
                  m_hold  = 1;
               end
            end
         end
      end
      e.grant = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
      e.id    = (m_owner >= 0) ? 4'(m_owner) : 4'd0;
      e.valid = (m_owner >= 0);
      e.tout  = m_tout;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs away from the rising edge, and record what
   // the model expects after the next rising edge.
   task automatic applyStimulus(input bit rst, input bit en, input logic [15:0] r, input bit dn);
      @(negedge clk);
      reset  = rst;
      enable = en;
      req    = r;
      done   = dn;
      modelStep(rst, en, r, dn);
   endtask

   // Repeat the same inputs for several cycles.
   task automatic holdStimulus(input int n, input bit rst, input bit en, input logic [15:0] r, input bit dn);
      for (int i = 0; i < n; i++) begin
         applyStimulus(rst, en, r, dn);
      end
   endtask

   // Compare the full DUT output bundle with one scoreboard entry.
   task automatic checkOutput(input exp_t e);
      checks++;
      if (grant !== e.grant || grant_id !== e.id || grant_valid !== e.valid || timeout !== e.tout) begin
         errors++;
         $display("[TB] FAIL outputs cycle %0d: got grant=%h id=%0d valid=%b timeout=%b, expected grant=%h id=%0d valid=%b timeout=%b",
                  cycle, grant, grant_id, grant_valid, timeout, e.grant, e.id, e.valid, e.tout);
      end
   endtask

   // Monitor: just after each rising edge, pop the entry for that edge and
   // compare it with what the DUT now shows.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
         end
      end
   end

   // Stimulus: directed scenarios first, then a randomized soak.
   initial begin
      bit          rst_r;
      bit          en_r;
      bit          dn_r;
      logic [15:0] req_r;

      $display("[TB] reset");
      holdStimulus(3, 1, 0, 16'h0000, 0);

      $display("[TB] reset mid-grant");
      holdStimulus(3, 0, 1, 16'h0001, 0);
      applyStimulus(1, 1, 16'h0001, 0);
      holdStimulus(3, 0, 1, 16'h0003, 0);
      holdStimulus(4, 0, 1, 16'h0003, 1);

      $display("[TB] rotation with wrap");
      holdStimulus(2, 1, 0, 16'h0000, 0);
      holdStimulus(52, 0, 1, 16'hFFFF, 1);

      $display("[TB] pointer skip");
      holdStimulus(2, 1, 0, 16'h0000, 0);
      holdStimulus(2, 0, 1, 16'h0020, 0);
      applyStimulus(0, 1, 16'h0020, 1);
      holdStimulus(3, 0, 1, 16'h0021, 0);
      applyStimulus(0, 1, 16'h0021, 1);
      holdStimulus(4, 0, 1, 16'h0041, 0);
      applyStimulus(0, 1, 16'h0041, 1);

      $display("[TB] enable gating");
      holdStimulus(2, 1, 0, 16'h0000, 0);
      holdStimulus(10, 0, 0, 16'h0800, 0);
      holdStimulus(2, 0, 1, 16'h0800, 0);
      holdStimulus(5, 0, 0, 16'h0800, 0);
      applyStimulus(0, 0, 16'h0800, 1);
      holdStimulus(3, 0, 0, 16'h0000, 0);

      $display("[TB] request drop");
      holdStimulus(2, 1, 0, 16'h0000, 0);
      holdStimulus(3, 0, 1, 16'h0300, 0);
      holdStimulus(4, 0, 1, 16'h0200, 0);

`ifdef RR_ARB_TIMEOUT_EN
      $display("[TB] timeout");
      holdStimulus(2, 1, 0, 16'h0000, 0);
      holdStimulus(14, 0, 1, 16'h8000, 0);

      $display("[TB] voluntary release beats timeout");
      holdStimulus(2, 1, 0, 16'h0000, 0);
      holdStimulus(4, 0, 1, 16'h8000, 0);
      applyStimulus(0, 1, 16'h8000, 1);
      holdStimulus(4, 0, 1, 16'h8000, 0);
`endif

      $display("[TB] random soak");
      holdStimulus(2, 1, 0, 16'h0000, 0);
      for (int i = 0; i < 3000; i++) begin
         rst_r = ($urandom_range(0, 199) == 0);
         en_r  = ($urandom_range(0, 9) < 8);
         dn_r  = ($urandom_range(0, 5) == 0);
         req_r = 16'($urandom) & 16'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            req_r = req_r | 16'($urandom);
         end
         applyStimulus(rst_r, en_r, req_r, dn_r);
      end

      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
